// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_pkg                                                              |
// | Shared types and constants for the CNN forward-pass blocks.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package cnn_pkg;

  // Default signed element width used by the feature-map buffers
  localparam int DEF_DATA_W = 8;

  // Pooling window edge length (2x2 window, stride 2)
  localparam int POOL_WIN = 2;

  // Pooling engine control states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_LOW = 3'd4
  } pool_state_e;

endpackage
`default_nettype wire

// File: rtl/pool_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_addr_gen                                                        |
// | Walks the input map window by window (raster order), emitting one    |
// | read address per issue, a last-read flag, and the element index      |
// | re-timed to line up with the returning read data.                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int FMAP_H = 8,
  parameter int FMAP_W = 8,
  parameter int ADDR_W = $clog2(FMAP_H * FMAP_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              issue_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              last_o,
  output logic              tag_vld_o,
  output logic [1:0]        tag_elem_o
);

  localparam int WIN_ROWS = FMAP_H / POOL_WIN;
  localparam int WIN_COLS = FMAP_W / POOL_WIN;
  localparam int R_W      = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
  localparam int C_W      = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;

  localparam logic [R_W-1:0]    R_LAST      = R_W'(WIN_ROWS - 1);
  localparam logic [R_W-1:0]    R_ONE       = R_W'(1);
  localparam logic [C_W-1:0]    C_LAST      = C_W'(WIN_COLS - 1);
  localparam logic [C_W-1:0]    C_ONE       = C_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_ROW       = ADDR_W'(FMAP_W);
  localparam logic [ADDR_W-1:0] A_COL_STEP  = ADDR_W'(POOL_WIN);
  // From the last window of a row pair (base = 2r*W + W-2) to the first
  // window of the next pair (base = (2r+2)*W).
  localparam logic [ADDR_W-1:0] A_PAIR_STEP = ADDR_W'(FMAP_W + POOL_WIN);

  logic [R_W-1:0]    r_q, r_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [1:0]        e_q, e_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_w;

  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        elem1_q;
  logic              tag_vld_q;
  logic [1:0]        tag_elem_q;

  // Element address = window base + row offset (elem bit 1) + column offset (elem bit 0)
  always_comb begin
    addr_w = base_q;
    if (e_q[1]) addr_w = addr_w + A_ROW;
    if (e_q[0]) addr_w = addr_w + A_ONE;
  end

  // Window/element counter advance, one element per issued read
  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    e_d    = e_q;
    base_d = base_q;
    if (clear_i) begin
      r_d    = '0;
      c_d    = '0;
      e_d    = '0;
      base_d = '0;
    end else if (issue_i) begin
      e_d = e_q + 2'd1;
      if (e_q == 2'd3) begin
        if (c_q == C_LAST) begin
          c_d    = '0;
          base_d = base_q + A_PAIR_STEP;
          r_d    = (r_q == R_LAST) ? '0 : (r_q + R_ONE);
        end else begin
          c_d    = c_q + C_ONE;
          base_d = base_q + A_COL_STEP;
        end
      end
    end
  end

  assign last_o = (e_q == 2'd3) && (c_q == C_LAST) && (r_q == R_LAST);

  // Counter state plus the read strobe/address and a two-stage element tag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q        <= '0;
      c_q        <= '0;
      e_q        <= '0;
      base_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      elem1_q    <= '0;
      tag_vld_q  <= 1'b0;
      tag_elem_q <= '0;
    end else begin
      r_q        <= r_d;
      c_q        <= c_d;
      e_q        <= e_d;
      base_q     <= base_d;
      rd_en_q    <= issue_i;
      if (issue_i) begin
        rd_addr_q <= addr_w;
        elem1_q   <= e_q;
      end
      tag_vld_q  <= rd_en_q;
      tag_elem_q <= elem1_q;
    end
  end

  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = rd_addr_q;
  assign tag_vld_o  = tag_vld_q;
  assign tag_elem_o = tag_elem_q;

endmodule
`default_nettype wire

// File: rtl/max_pool_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | max_pool_unit                                                        |
// | 2x2 stride-2 signed max-pooling engine. Streams the input map from   |
// | a read-latency-1 buffer, keeps a running max per window and writes   |
// | one pooled element every 4 cycles, then pulses done_p.               |
// | Build option: POOL_RELU_EN - clamp pooled results to >= 0.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module max_pool_unit
  import cnn_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FMAP_H  = 8,
  parameter int FMAP_W  = 8,
  parameter int ADDR_W  = $clog2(FMAP_H * FMAP_W),
  parameter int OADDR_W = $clog2(FMAP_H * FMAP_W / 4)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_load,
  output logic               done_p,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               wr_en,
  output logic [OADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy
);

  if ((FMAP_H < 2) || ((FMAP_H % 2) != 0)) begin : g_bad_fmap_h
    $error("max_pool_unit: FMAP_H must be even and >= 2");
  end
  if ((FMAP_W < 2) || ((FMAP_W % 2) != 0)) begin : g_bad_fmap_w
    $error("max_pool_unit: FMAP_W must be even and >= 2");
  end

  localparam logic [OADDR_W-1:0] K_ONE = OADDR_W'(1);

  pool_state_e        state_q, state_d;
  logic               drain_q, drain_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [OADDR_W-1:0] k_q, k_d;
  logic [DATA_W-1:0]  mx_q, mx_d;
  logic               wr_en_q, wr_en_d;
  logic [OADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic               issue_w;
  logic               clear_w;
  logic               last_w;
  logic               tag_vld_w;
  logic [1:0]         tag_elem_w;
  logic [DATA_W-1:0]  max_w;
  logic [DATA_W-1:0]  res_w;

  assign issue_w = (state_q == ST_READ);
  assign clear_w = (state_q == ST_IDLE);

  pool_addr_gen #(
    .FMAP_H (FMAP_H),
    .FMAP_W (FMAP_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear_w),
    .issue_i    (issue_w),
    .rd_en_o    (rd_en),
    .rd_addr_o  (rd_addr),
    .last_o     (last_w),
    .tag_vld_o  (tag_vld_w),
    .tag_elem_o (tag_elem_w)
  );

  // Control FSM: next state, drain counter and registered status flags.
  // busy/done follow the current state so they line up with rd_en timing.
  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    case (state_q)
      ST_IDLE:     if (p_load) state_d = ST_READ;
      ST_READ:     if (last_w) state_d = ST_DRAIN;
      ST_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = ST_DONE;
      end
      ST_DONE:     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!p_load) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    done_d = (state_q == ST_DONE);
    busy_d = (state_q != ST_IDLE);
  end

  // Compare datapath: running max per window, write on the fourth element
  always_comb begin
    max_w = ($signed(rd_data) > $signed(mx_q)) ? rd_data : mx_q;
`ifdef POOL_RELU_EN
    res_w = max_w[DATA_W-1] ? '0 : max_w;
`else
    res_w = max_w;
`endif
    mx_d      = mx_q;
    k_d       = k_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (clear_w) k_d = '0;
    if (tag_vld_w) begin
      mx_d = (tag_elem_w == 2'd0) ? rd_data : max_w;
      if (tag_elem_w == 2'd3) begin
        wr_en_d   = 1'b1;
        wr_addr_d = k_q;
        wr_data_d = res_w;
        k_d       = k_q + K_ONE;
      end
    end
  end

  // State and output registers; reset drops any in-flight window
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      drain_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      k_q       <= '0;
      mx_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      k_q       <= k_d;
      mx_q      <= mx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign done_p  = done_q;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_max_pool_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_max_pool_unit                                                     |
// | Directed self-checking bench: a 4x4 instance and a 2x6 instance,     |
// | each backed by a read-latency-1 memory model.                        |
// | Expected results honour POOL_RELU_EN when it is defined.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_max_pool_unit;

  logic       clk;
  logic       reset;
  logic       p_load;
  logic       pl_r;

  // 4x4 instance
  logic       done_p, rd_en, wr_en, busy;
  logic [3:0] rd_addr;
  logic [7:0] rd_data, wr_data;
  logic [1:0] wr_addr;

  // 2x6 instance
  logic       done_r, rd_en_r, wr_en_r, busy_r;
  logic [3:0] rd_addr_r;
  logic [7:0] rd_data_r, wr_data_r;
  logic [1:0] wr_addr_r;

  logic [7:0] mem4 [16];
  logic [7:0] memr [16];

  int checks = 0;
  int fails  = 0;

  int addr4 [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int addrr [12] = '{0, 1, 6, 7, 2, 3, 8, 9, 4, 5, 10, 11};

  max_pool_unit #(
    .DATA_W (8), .FMAP_H (4), .FMAP_W (4)
  ) u_dut (
    .clk (clk), .reset (reset), .p_load (p_load), .done_p (done_p),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .busy (busy)
  );

  max_pool_unit #(
    .DATA_W (8), .FMAP_H (2), .FMAP_W (6)
  ) u_dut_r (
    .clk (clk), .reset (reset), .p_load (pl_r), .done_p (done_r),
    .rd_en (rd_en_r), .rd_addr (rd_addr_r), .rd_data (rd_data_r),
    .wr_en (wr_en_r), .wr_addr (wr_addr_r), .wr_data (wr_data_r), .busy (busy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input buffers: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en)   rd_data   <= mem4[rd_addr];
    if (rd_en_r) rd_data_r <= memr[rd_addr_r];
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] relu8(input logic [7:0] v);
`ifdef POOL_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) mem4[i] = 8'(i);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem4[i] = v;
  endtask

  // One run on the 4x4 instance. Entered between edges; p_load is sampled
  // high at the next edge (cycle 0) and held while cycle < hold_last.
  // rst_at > 0 asserts reset so that it is sampled at edge rst_at+1.
  task automatic run4(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3,
                      input int hold_last, input int rst_at, input int ncyc);
    logic [7:0] ex [4];
    bit         we, hi, lo;
    int         k, lo_from;
    ex[0] = relu8(e0); ex[1] = relu8(e1); ex[2] = relu8(e2); ex[3] = relu8(e3);
    lo_from = (hold_last + 2 > 21) ? hold_last + 2 : 21;
    p_load = 1'b1;
    @(posedge clk);
    #1;
    p_load = (0 < hold_last);
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      p_load = (n < hold_last);
      reset  = (rst_at > 0) && (n == rst_at);
      @(negedge clk);
      if (rst_at > 0 && n > rst_at) begin
        chk_eq($sformatf("%s c%0d rst rd_en", nm, n),   32'(rd_en),   32'd0);
        chk_eq($sformatf("%s c%0d rst rd_addr", nm, n), 32'(rd_addr), 32'd0);
        chk_eq($sformatf("%s c%0d rst wr_en", nm, n),   32'(wr_en),   32'd0);
        chk_eq($sformatf("%s c%0d rst wr_addr", nm, n), 32'(wr_addr), 32'd0);
        chk_eq($sformatf("%s c%0d rst wr_data", nm, n), 32'(wr_data), 32'd0);
        chk_eq($sformatf("%s c%0d rst done_p", nm, n),  32'(done_p),  32'd0);
        chk_eq($sformatf("%s c%0d rst busy", nm, n),    32'(busy),    32'd0);
      end else begin
        chk_eq($sformatf("%s c%0d rd_en", nm, n), 32'(rd_en), 32'(n <= 16));
        if (n <= 16)
          chk_eq($sformatf("%s c%0d rd_addr", nm, n), 32'(rd_addr), 32'(addr4[n-1]));
        we = (n >= 6) && (n <= 18) && (((n - 6) % 4) == 0);
        chk_eq($sformatf("%s c%0d wr_en", nm, n), 32'(wr_en), 32'(we));
        if (we) begin
          k = (n - 6) / 4;
          chk_eq($sformatf("%s c%0d wr_addr", nm, n), 32'(wr_addr), 32'(k));
          chk_eq($sformatf("%s c%0d wr_data", nm, n), 32'(wr_data), 32'(ex[k]));
        end
        chk_eq($sformatf("%s c%0d done_p", nm, n), 32'(done_p), 32'(n == 19));
        hi = (n <= 19) || (n <= hold_last + 1);
        lo = (n >= lo_from);
        if (hi) chk_eq($sformatf("%s c%0d busy", nm, n), 32'(busy), 32'd1);
        else if (lo) chk_eq($sformatf("%s c%0d busy", nm, n), 32'(busy), 32'd0);
      end
    end
    reset = 1'b0;
  endtask

  // One pulsed run on the 2x6 instance
  task automatic run_rect();
    logic [7:0] ex [3];
    bit         we;
    ex[0] = relu8(8'd7); ex[1] = relu8(8'd9); ex[2] = relu8(8'd11);
    pl_r = 1'b1;
    @(posedge clk);
    #1;
    pl_r = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk_eq($sformatf("rect c%0d rd_en", n), 32'(rd_en_r), 32'(n <= 12));
      if (n <= 12)
        chk_eq($sformatf("rect c%0d rd_addr", n), 32'(rd_addr_r), 32'(addrr[n-1]));
      we = (n == 6) || (n == 10) || (n == 14);
      chk_eq($sformatf("rect c%0d wr_en", n), 32'(wr_en_r), 32'(we));
      if (we) begin
        chk_eq($sformatf("rect c%0d wr_addr", n), 32'(wr_addr_r), 32'((n - 6) / 4));
        chk_eq($sformatf("rect c%0d wr_data", n), 32'(wr_data_r), 32'(ex[(n - 6) / 4]));
      end
      chk_eq($sformatf("rect c%0d done_p", n), 32'(done_r), 32'(n == 15));
    end
  endtask

  initial begin
    reset  = 1'b1;
    p_load = 1'b0;
    pl_r   = 1'b0;
    fill_ramp();
    for (int i = 0; i < 16; i++) memr[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_eq("reset done_p",  32'(done_p),  32'd0);
    chk_eq("reset rd_en",   32'(rd_en),   32'd0);
    chk_eq("reset wr_en",   32'(wr_en),   32'd0);
    chk_eq("reset busy",    32'(busy),    32'd0);
    chk_eq("reset rd_addr", 32'(rd_addr), 32'd0);
    chk_eq("reset wr_addr", 32'(wr_addr), 32'd0);
    chk_eq("reset wr_data", 32'(wr_data), 32'd0);
    chk_eq("reset r done_p", 32'(done_r),  32'd0);
    chk_eq("reset r busy",   32'(busy_r),  32'd0);
    chk_eq("reset r rd_en",  32'(rd_en_r), 32'd0);
    chk_eq("reset r wr_en",  32'(wr_en_r), 32'd0);

    // Ramp: windows {0,1,4,5} {2,3,6,7} {8,9,12,13} {10,11,14,15}
    run4("ramp", 8'd5, 8'd7, 8'd13, 8'd15, 0, 0, 24);

    // Negative fill
    fill_const(8'hFD);
    run4("neg", 8'hFD, 8'hFD, 8'hFD, 8'hFD, 0, 0, 22);

    // Extremes plus two more mixed windows
    mem4[0]  = 8'h80; mem4[1]  = 8'h7F; mem4[4]  = 8'hFF; mem4[5]  = 8'h00;
    mem4[2]  = 8'h80; mem4[3]  = 8'h80; mem4[6]  = 8'h80; mem4[7]  = 8'h80;
    mem4[8]  = 8'hFB; mem4[9]  = 8'hF9; mem4[12] = 8'hFE; mem4[13] = 8'hF7;
    mem4[10] = 8'h01; mem4[11] = 8'hFF; mem4[14] = 8'd100; mem4[15] = 8'h03;
    run4("ext", 8'h7F, 8'h80, 8'hFE, 8'd100, 0, 0, 22);

    // Held start through cycle 25, re-raised so it is sampled at cycle 30
    fill_ramp();
    run4("held", 8'd5, 8'd7, 8'd13, 8'd15, 25, 0, 29);
    run4("held2", 8'd5, 8'd7, 8'd13, 8'd15, 0, 0, 22);

    // Reset mid-run, then a clean run
    run4("rstmid", 8'd5, 8'd7, 8'd13, 8'd15, 0, 8, 22);
    run4("after", 8'd5, 8'd7, 8'd13, 8'd15, 0, 0, 22);

    // Rectangular 2x6 map
    run_rect();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
